// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA encodings and the EX-stage ALU op-select used by the pre-decoder.
package mips_isa_pkg;

    // Primary opcodes
    localparam logic [5:0] OPC_R     = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_SLTIU = 6'h0B;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    // R-format funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // ALU op select. OP_SLL must stay at encoding 0: it is the reset decode
    // of an all-zero opcode/funct.
    typedef enum logic [4:0] {
        OP_SLL   = 5'd0,
        OP_SRL   = 5'd1,
        OP_SRA   = 5'd2,
        OP_SLLV  = 5'd3,
        OP_SRLV  = 5'd4,
        OP_SRAV  = 5'd5,
        OP_ADD   = 5'd6,   // rs + rt
        OP_SUB   = 5'd7,
        OP_AND   = 5'd8,
        OP_OR    = 5'd9,
        OP_XOR   = 5'd10,
        OP_NOR   = 5'd11,
        OP_SLT   = 5'd12,
        OP_SLTU  = 5'd13,
        OP_ADDS  = 5'd14,  // rs + sext(imm): ADDI/ADDIU/LW/SW
        OP_SLTI  = 5'd15,
        OP_SLTIU = 5'd16,
        OP_ANDI  = 5'd17,
        OP_ORI   = 5'd18,
        OP_XORI  = 5'd19,
        OP_LUI   = 5'd20,
        OP_ZERO  = 5'd21   // branches, jumps, unknown encodings
    } alu_op_e;

    // Opcode/funct pair carried from ID to EX
    typedef struct packed {
        logic [5:0] opcode;
        logic [5:0] funct;
    } insn_id_t;

endpackage

// File: rtl/mips_alu_decode.sv
// Combinational opcode/funct to ALU op-select decoder.
module mips_alu_decode
    import mips_isa_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output alu_op_e    op
);

    // Map the instruction encoding onto one ALU op; anything unlisted yields zero
    always_comb begin
        op = OP_ZERO;
        case (opcode)
            OPC_R: begin
                case (funct)
                    FN_SLL:          op = OP_SLL;
                    FN_SRL:          op = OP_SRL;
                    FN_SRA:          op = OP_SRA;
                    FN_SLLV:         op = OP_SLLV;
                    FN_SRLV:         op = OP_SRLV;
                    FN_SRAV:         op = OP_SRAV;
                    FN_ADD, FN_ADDU: op = OP_ADD;
                    FN_SUB, FN_SUBU: op = OP_SUB;
                    FN_AND:          op = OP_AND;
                    FN_OR:           op = OP_OR;
                    FN_XOR:          op = OP_XOR;
                    FN_NOR:          op = OP_NOR;
                    FN_SLT:          op = OP_SLT;
                    FN_SLTU:         op = OP_SLTU;
                    default:         op = OP_ZERO;
                endcase
            end
            OPC_ADDI, OPC_ADDIU,
            OPC_LW, OPC_SW:  op = OP_ADDS;
            OPC_SLTI:        op = OP_SLTI;
            OPC_SLTIU:       op = OP_SLTIU;
            OPC_ANDI:        op = OP_ANDI;
            OPC_ORI:         op = OP_ORI;
            OPC_XORI:        op = OP_XORI;
            OPC_LUI:         op = OP_LUI;
            default:         op = OP_ZERO;
        endcase
    end

endmodule

// File: rtl/mips_exec_alu.sv
// EX-stage registered ALU. The op select is decoded from the ID-stage
// opcode/funct one cycle early so EX only sees a registered select.
module mips_exec_alu
    import mips_isa_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode_fwd,
    input  logic [5:0]  funct_fwd,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [31:0] rrs,
    input  logic [31:0] rrt_in,
    input  logic [15:0] imm,
    input  logic [4:0]  shamt_in,
    output logic [31:0] rslt
);

    alu_op_e     op_dec;
    alu_op_e     op_q;
    logic [31:0] sext_imm;
    logic [31:0] zext_imm;
    logic [31:0] alu_res;

    mips_alu_decode u_dec (
        .opcode (opcode_fwd),
        .funct  (funct_fwd),
        .op     (op_dec)
    );

    // Pre-decode register: select used by the instruction entering EX next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) op_q <= OP_SLL;
        else     op_q <= op_dec;
    end

    assign sext_imm = {{16{imm[15]}}, imm};
    assign zext_imm = {16'h0000, imm};

    // Datapath driven purely by the registered select
    always_comb begin
        alu_res = 32'h0;
        case (op_q)
            OP_SLL:   alu_res = rrt_in << shamt_in;
            OP_SRL:   alu_res = rrt_in >> shamt_in;
            OP_SRA:   alu_res = $unsigned($signed(rrt_in) >>> shamt_in);
            OP_SLLV:  alu_res = rrt_in << rrs[4:0];
            OP_SRLV:  alu_res = rrt_in >> rrs[4:0];
            OP_SRAV:  alu_res = $unsigned($signed(rrt_in) >>> rrs[4:0]);
            OP_ADD:   alu_res = rrs + rrt_in;
            OP_SUB:   alu_res = rrs - rrt_in;
            OP_AND:   alu_res = rrs & rrt_in;
            OP_OR:    alu_res = rrs | rrt_in;
            OP_XOR:   alu_res = rrs ^ rrt_in;
            OP_NOR:   alu_res = ~(rrs | rrt_in);
            OP_SLT:   alu_res = {31'h0, $signed(rrs) < $signed(rrt_in)};
            OP_SLTU:  alu_res = {31'h0, rrs < rrt_in};
            OP_ADDS:  alu_res = rrs + sext_imm;
            OP_SLTI:  alu_res = {31'h0, $signed(rrs) < $signed(sext_imm)};
            OP_SLTIU: alu_res = {31'h0, rrs < sext_imm};
            OP_ANDI:  alu_res = rrs & zext_imm;
            OP_ORI:   alu_res = rrs | zext_imm;
            OP_XORI:  alu_res = rrs ^ zext_imm;
            OP_LUI:   alu_res = {imm, 16'h0000};
            default:  alu_res = 32'h0;
        endcase
    end

    // Result register, visible in MM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rslt <= 32'h0;
        else     rslt <= alu_res;
    end

`ifndef SYNTHESIS
    // Contract watch: the EX opcode/funct must match what was pre-decoded.
    // fwd_vld masks the first cycle after reset, when nothing was captured yet.
    insn_id_t fwd_q;
    logic     fwd_vld;
    logic     fwd_mismatch;

    // Capture the ID-stage encoding alongside the pre-decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_q   <= '0;
            fwd_vld <= 1'b0;
        end else begin
            fwd_q   <= '{opcode: opcode_fwd, funct: funct_fwd};
            fwd_vld <= 1'b1;
        end
    end

    assign fwd_mismatch = fwd_vld && (fwd_q != {opcode, funct});

    cover property (@(posedge clk) fwd_mismatch);
`endif

endmodule

// File: tb/tb_mips_exec_alu.sv
// Directed bench for mips_exec_alu: pipelined instruction stream with a
// scoreboard of hand-derived results, plus reset and contract-check cases.
module tb_mips_exec_alu;
    import mips_isa_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode_fwd, funct_fwd, opcode, funct;
    logic [31:0] rrs, rrt_in;
    logic [15:0] imm;
    logic [4:0]  shamt_in;
    logic [31:0] rslt;

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] im;
        logic [4:0]  sh;
        logic [31:0] exp;
        string       tag;
    } ins_t;

    typedef struct {
        logic [31:0] exp;
        string       tag;
    } sb_t;

    ins_t prog[$];
    sb_t  exp_q[$];

    mips_exec_alu dut (
        .clk        (clk),
        .rst        (rst),
        .opcode_fwd (opcode_fwd),
        .funct_fwd  (funct_fwd),
        .opcode     (opcode),
        .funct      (funct),
        .rrs        (rrs),
        .rrt_in     (rrt_in),
        .imm        (imm),
        .shamt_in   (shamt_in),
        .rslt       (rslt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [15:0] im, input logic [4:0] sh,
                       input logic [31:0] exp, input string tag);
        ins_t i;
        i.op = op; i.fn = fn; i.rs = rs; i.rt = rt; i.im = im; i.sh = sh;
        i.exp = exp; i.tag = tag;
        prog.push_back(i);
    endtask

    // Issue prog back-to-back: opcode_fwd leads opcode by one cycle
    task automatic run_prog();
        sb_t s;
        opcode_fwd = prog[0].op;
        funct_fwd  = prog[0].fn;
        @(posedge clk); #1;
        for (int i = 0; i < prog.size(); i++) begin
            opcode   = prog[i].op;
            funct    = prog[i].fn;
            rrs      = prog[i].rs;
            rrt_in   = prog[i].rt;
            imm      = prog[i].im;
            shamt_in = prog[i].sh;
            opcode_fwd = (i + 1 < prog.size()) ? prog[i+1].op : 6'h00;
            funct_fwd  = (i + 1 < prog.size()) ? prog[i+1].fn : 6'h00;
            s.exp = prog[i].exp;
            s.tag = prog[i].tag;
            exp_q.push_back(s);
            #1;
            chk({"fwd_ok_", prog[i].tag}, {31'h0, dut.fwd_mismatch}, 32'h0);
            @(posedge clk); #1;
            s = exp_q.pop_front();
            chk(s.tag, rslt, s.exp);
        end
        opcode = 6'h00;
        funct  = 6'h00;
        prog.delete();
    endtask

    initial begin
        rst = 1'b1;
        opcode_fwd = 6'h00; funct_fwd = 6'h00; opcode = 6'h00; funct = 6'h00;
        rrs = 32'h0; rrt_in = 32'h5; imm = 16'h0; shamt_in = 5'd0;

        // Reset state, then first result uses the SLL reset decode
        #12;
        chk("reset_rslt", rslt, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_sll", rslt, 32'h5);

        // Arithmetic, compare, logic, shifts, pipelined stream and extras
        add(OPC_R,     FN_ADDU, 32'hFFFFFFFF, 32'h1,        16'h0,    5'd0,  32'h00000000, "addu_wrap");
        add(OPC_R,     FN_SUB,  32'h3,        32'h5,        16'h0,    5'd0,  32'hFFFFFFFE, "sub_neg");
        add(OPC_ADDI,  6'h00,   32'h10,       32'h0,        16'hFFFF, 5'd0,  32'h0000000F, "addi_sext");
        add(OPC_R,     FN_SLT,  32'hFFFFFFFF, 32'h1,        16'h0,    5'd0,  32'h1,        "slt_signed");
        add(OPC_R,     FN_SLTU, 32'hFFFFFFFF, 32'h1,        16'h0,    5'd0,  32'h0,        "sltu_unsigned");
        add(OPC_SLTIU, 6'h00,   32'h5,        32'h0,        16'hFFFF, 5'd0,  32'h1,        "sltiu_sext");
        add(OPC_ORI,   6'h00,   32'hF0000000, 32'h0,        16'h8001, 5'd0,  32'hF0008001, "ori_zext");
        add(OPC_R,     FN_NOR,  32'h0,        32'h0,        16'h0,    5'd0,  32'hFFFFFFFF, "nor_zero");
        add(OPC_LUI,   6'h00,   32'hDEADBEEF, 32'h0,        16'h1234, 5'd0,  32'h12340000, "lui");
        add(OPC_R,     FN_SRA,  32'h0,        32'h80000000, 16'h0,    5'd4,  32'hF8000000, "sra4");
        add(OPC_R,     FN_SRLV, 32'd36,       32'h80000000, 16'h0,    5'd0,  32'h08000000, "srlv_mod32");
        add(OPC_R,     FN_SLL,  32'h0,        32'h1,        16'h0,    5'd31, 32'h80000000, "sll31");
        add(OPC_R,     FN_ADDU, 32'h1234,     32'h1111,     16'h0,    5'd0,  32'h00002345, "b2b_addu");
        add(OPC_LW,    6'h00,   32'h100,      32'h0,        16'hFFFC, 5'd0,  32'h000000FC, "b2b_lw");
        add(OPC_BEQ,   6'h00,   32'h5,        32'h5,        16'h0003, 5'd0,  32'h0,        "b2b_beq");
        add(OPC_R,     FN_XOR,  32'hFF00FF00, 32'h0FF00FF0, 16'h0,    5'd0,  32'hF0F0F0F0, "b2b_xor");
        add(OPC_R,     FN_SRL,  32'h0,        32'h80000000, 16'h0,    5'd31, 32'h00000001, "srl31");
        add(OPC_R,     FN_SRAV, 32'h21,       32'h80000000, 16'h0,    5'd0,  32'hC0000000, "srav1");
        add(OPC_R,     FN_SLLV, 32'h0,        32'hA5,       16'h0,    5'd7,  32'h000000A5, "sllv0");
        add(OPC_R,     FN_AND,  32'hF0F0,     32'hFF00,     16'h0,    5'd0,  32'h0000F000, "and");
        add(OPC_ANDI,  6'h00,   32'hFFFFFFFF, 32'h0,        16'h8001, 5'd0,  32'h00008001, "andi_zext");
        add(OPC_XORI,  6'h00,   32'hFFFF0000, 32'h0,        16'hFFFF, 5'd0,  32'hFFFFFFFF, "xori");
        add(OPC_SLTI,  6'h00,   32'hFFFFFFF0, 32'h0,        16'hFFFF, 5'd0,  32'h1,        "slti_neg");
        add(OPC_SLTI,  6'h00,   32'h5,        32'h0,        16'hFFFF, 5'd0,  32'h0,        "slti_pos");
        add(OPC_SW,    6'h00,   32'h1000,     32'h0,        16'h0008, 5'd0,  32'h00001008, "sw_addr");
        add(OPC_J,     6'h00,   32'h1,        32'h1,        16'hFFFF, 5'd0,  32'h0,        "j_zero");
        add(OPC_R,     6'h01,   32'h7,        32'h7,        16'h0,    5'd0,  32'h0,        "bad_funct");
        add(OPC_R,     FN_ADD,  32'h7FFFFFFF, 32'h1,        16'h0,    5'd0,  32'h80000000, "add_nowrap_trap");
        add(OPC_R,     FN_SUBU, 32'h0,        32'h1,        16'h0,    5'd0,  32'hFFFFFFFF, "subu");
        run_prog();

        // Mid-stream asynchronous reset with a non-zero result present
        add(OPC_LUI,   6'h00,   32'h0,        32'h0,        16'hBEEF, 5'd0,  32'hBEEF0000, "lui_pre_rst");
        run_prog();
        rrs = 32'h0; rrt_in = 32'h5; imm = 16'h0; shamt_in = 5'd0;
        opcode_fwd = OPC_LUI;  // must be ignored while reset holds the decode
        #2 rst = 1'b1;
        #1;
        chk("async_rst", rslt, 32'h0);
        opcode_fwd = 6'h00;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_resume_sll", rslt, 32'h5);

        // Deliberate contract violation: EX says ORI, pre-decode says ADDIU
        opcode_fwd = OPC_ADDIU; funct_fwd = 6'h00;
        @(posedge clk); #1;
        opcode = OPC_ORI; funct = 6'h00;
        rrs = 32'h10; imm = 16'hFFFF;
        opcode_fwd = 6'h00;
        #1;
        chk("mismatch_flag", {31'h0, dut.fwd_mismatch}, 32'h1);
        @(posedge clk); #1;
        chk("mismatch_uses_predecode", rslt, 32'h0000000F);
        opcode = 6'h00;
        #1;
        chk("mismatch_clear", {31'h0, dut.fwd_mismatch}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mips_exec_alu.md
Name: mips_exec_alu

Overview:
- Registered 32-bit integer ALU for the EX stage of the 7-stage MIPS pipeline (IF, IG, ID, EX, MM, WB, WC).
- Computes R-format, I-format arithmetic/logic and load/store address results.
- The result is registered, so it appears in the MM stage. It feeds the data-memory address, MM-stage forwarding and WB write-back.
- To shorten the EX critical path, the operation select is pre-decoded one cycle early from the ID-stage opcode/funct.

Parameters:
- none: the datapath is fixed at 32 bits; shamt is 5 bits and the immediate is 16 bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- opcode_fwd  in  6  opcode of the instruction now in ID; it becomes `opcode` next cycle.
- funct_fwd  in  6  funct of the instruction now in ID.
- opcode  in  6  opcode of the instruction now in EX.
- funct  in  6  funct of the instruction now in EX.
- rrs  in  32  rs operand, already forwarded.
- rrt_in  in  32  rt operand, already forwarded.
- imm  in  16  I-format immediate.
- shamt_in  in  5  shift amount field.
- rslt  out  32  registered result.

Behaviour:
- Reset (asynchronous, active-high): rslt = 0. The pre-decode register is cleared to the all-zero decode (opcode 0, funct 0 = SLL).
- Pre-decode: each clk edge registers decode(opcode_fwd, funct_fwd) into an internal one-hot/encoded op select. That select is used in the following cycle.
- Contract: opcode/funct in cycle n+1 equal opcode_fwd/funct_fwd in cycle n.
  - opcode/funct are used only by a simulation-only check that flags a mismatch with the pre-decode.
  - The result is always computed from the pre-decode.
- Latency: 1 cycle. rslt after edge k = f(op, rrs, rrt_in, imm, shamt_in), with operands sampled at edge k.
- sext(imm) means sign-extend to 32 bits; zext(imm) means zero-extend.
- R-format (opcode 0), selected by funct:
  - SLL 0x00: rt << shamt.
  - SRL 0x02: logical shift right of rt by shamt.
  - SRA 0x03: arithmetic shift right of rt by shamt.
  - SLLV 0x04 / SRLV 0x06 / SRAV 0x07: as SLL/SRL/SRA, shift amount = rs[4:0].
  - ADD 0x20 / ADDU 0x21: rs+rt.
  - SUB 0x22 / SUBU 0x23: rs-rt.
  - AND 0x24, OR 0x25, XOR 0x26: bitwise rs op rt.
  - NOR 0x27: ~(rs|rt).
  - SLT 0x2A: signed rs<rt gives 1, else 0.
  - SLTU 0x2B: unsigned rs<rt gives 1, else 0.
  - Any other funct: 0.
- I-format, selected by opcode:
  - ADDI 0x08 / ADDIU 0x09: rs+sext(imm).
  - SLTI 0x0A: signed rs<sext(imm).
  - SLTIU 0x0B: unsigned rs<sext(imm).
  - ANDI 0x0C, ORI 0x0D, XORI 0x0E: rs op zext(imm).
  - LUI 0x0F: {imm,16'h0}.
  - LW 0x23 / SW 0x2B: rs+sext(imm), the byte address.
- BEQ 0x04, BNE 0x05, J 0x02 and any other opcode: rslt = 0. Branch resolution is outside this block.
- Arithmetic wraps modulo 2^32. No overflow traps or flags; ADD behaves as ADDU.
- Shift amount is 5 bits; shifts by 0 return rt unchanged.
- No stall or valid input: the block computes every cycle. Squashing is handled by pipeline valid bits outside the block.
- Reset asserted mid-stream clears rslt immediately. The first post-reset result uses the SLL decode of all-zero opcode/funct.

Decomposition:
- Shared package `mips_isa_pkg`:
  - opcode localparams (R, J, BEQ, BNE, ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI, LW, SW);
  - funct localparams;
  - the ALU op-select enum.
- One sub-module, `mips_alu_decode`: combinational (opcode, funct) to op-select. It is instantiated once on the _fwd inputs feeding the pre-decode register.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with a non-zero result pending -> rslt=0 immediately; first op after release with opcode_fwd=0, funct_fwd=0, rt=0x5, shamt=0 -> rslt=0x5.
- Arithmetic: ADDU rs=0xFFFFFFFF, rt=1 -> 0x00000000. SUB rs=3, rt=5 -> 0xFFFFFFFE. ADDI rs=0x10, imm=0xFFFF -> 0x0000000F.
- Compare: SLT rs=0xFFFFFFFF, rt=1 -> 1. SLTU same operands -> 0. SLTIU rs=5, imm=0xFFFF -> 1.
- Logic/LUI: ORI rs=0xF0000000, imm=0x8001 -> 0xF0008001. NOR rs=0, rt=0 -> 0xFFFFFFFF. LUI imm=0x1234 -> 0x12340000.
- Shifts: SRA rt=0x80000000, shamt=4 -> 0xF8000000. SRLV rs=36, rt=0x80000000 (shift by 4) -> 0x08000000. SLL shamt=31, rt=1 -> 0x80000000.
- Back-to-back pipelining: a different op every cycle (ADDU, LW rs=0x100 imm=0xFFFC, BEQ, XOR) with opcode_fwd leading opcode by one cycle -> results 1 cycle later: correct sum, 0xFC, 0, correct xor. A deliberate fwd/EX mismatch triggers the simulation check.
